ps2_scancode_rx: RTL and testbench



---
 rtl/ps2_scancode_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 keyboard receiver: filters ps2_clk, deframes bytes, resolves
// E0/F0/E1 prefixes and emits one-cycle key events for the matrix block.
// Ports: clk_sys, reset_n (async low), ps2_clk/ps2_data (raw, async),
//        key_strobe, key_pressed, key_extended, key_code[7:0], frame_err.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RX   = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] F_MAX = 8'(FILTER_LEN - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_f;
    logic [7:0]    flt_cnt;
    logic          flt_flip;
    logic          sample;
    logic          bit_in;

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          ext;
    logic          brk;
    logic [2:0]    skip;
    logic          frame_ok;
    logic [7:0]    rx_byte;
    logic          is_ignored;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive
    // differing sample; any agreeing sample restarts the run.
    assign flt_flip = (clk_sync[1] != clk_f) && (flt_cnt == F_MAX);
    assign sample   = flt_flip && clk_f;
    assign bit_in   = dat_sync[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_f   <= 1'b1;
            flt_cnt <= 8'd0;
        end else if (clk_sync[1] == clk_f) begin
            flt_cnt <= 8'd0;
        end else if (flt_flip) begin
            clk_f   <= ~clk_f;
            flt_cnt <= 8'd0;
        end else begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end

    // After the stop bit: shreg = {stop, parity, d7..d0}.
    assign rx_byte  = shreg[7:0];
    assign frame_ok = (^shreg[8:0]) && shreg[9];

    always_comb begin
        is_ignored = 1'b0;
        unique case (rx_byte)
            8'h00, 8'hAA, 8'hEE,
            8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:             is_ignored = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 10'd0;
            tcnt         <= '0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            skip         <= 3'd0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
            frame_err    <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (sample && !bit_in) begin
                        state   <= S_RX;
                        bit_cnt <= 4'd1;
                        tcnt    <= '0;
                    end
                end
                S_RX: begin
                    // A sample edge beats a coincident timeout.
                    if (sample) begin
                        shreg <= {bit_in, shreg[9:1]};
                        tcnt  <= '0;
                        if (bit_cnt == 4'd10) begin
                            state <= S_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (tcnt == T_MAX) begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                        skip      <= 3'd0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                        skip      <= 3'd0;
                    end else if (skip != 3'd0) begin
                        skip <= skip - 3'd1;
                    end else if (rx_byte == 8'hE1) begin
                        // Swallow the other seven Pause bytes.
                        skip <= 3'd7;
                    end else if (rx_byte == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (rx_byte == 8'hF0) begin
                        brk <= 1'b1;
                    end else if (is_ignored) begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end else begin
                        key_code     <= rx_byte;
                        key_extended <= ext;
                        key_pressed  <= ~brk;
                        key_strobe   <= 1'b1;
                        ext          <= 1'b0;
                        brk          <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: table of PS/2 frames with expected events,
// scoreboard queue checked by a monitor, plus timeout and reset sequences.
module tb_ps2_scancode_rx;

    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int H  = 40;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // kind: 0 none, 1 key event, 2 frame error
    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         kind;
        logic [7:0] code;
        bit         pressed;
        bit         ext;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] code;
        bit         pressed;
        bit         ext;
        longint     cyc;
    } ev_t;

    vec_t   tbl[$];
    ev_t    sb[$];
    longint cyc = 0;
    longint last_fall;
    int     checks = 0;
    int     failures = 0;
    bit     prev_strobe = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs,
                                input int k, input logic [7:0] c,
                                input bit p, input bit e);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs;
        v.kind = k; v.code = c; v.pressed = p; v.ext = e;
        return v;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive the first nbits of a frame; expectation is queued at the stop edge.
    task automatic send_frame(input vec_t v, input int nbits);
        logic [10:0] bits;
        ev_t e;
        bits = {~v.bad_stop, (~^v.data) ^ v.bad_par, v.data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk_sys);
            ps2_clk = 1'b0;
            last_fall = cyc;
            if (i == 10 && v.kind != 0) begin
                e.kind = v.kind; e.code = v.code;
                e.pressed = v.pressed; e.ext = v.ext;
                e.cyc = cyc + FL + 3;
                sb.push_back(e);
            end
            repeat (H) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * H) @(negedge clk_sys);
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && (key_strobe || frame_err)) begin
            ev_t e;
            int  got_kind;
            got_kind = frame_err ? 2 : 1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: kind=%0d code=%0h at cyc %0d",
                         got_kind, key_code, cyc);
            end else begin
                e = sb.pop_front();
                if (got_kind != e.kind || cyc != e.cyc ||
                    (e.kind == 1 && (key_code != e.code ||
                     key_pressed != e.pressed || key_extended != e.ext))) begin
                    failures++;
                    $display("FAIL event: got kind=%0d code=%0h pr=%0b ex=%0b cyc=%0d expected kind=%0d code=%0h pr=%0b ex=%0b cyc=%0d",
                             got_kind, key_code, key_pressed, key_extended, cyc,
                             e.kind, e.code, e.pressed, e.ext, e.cyc);
                end
            end
            if (key_strobe) begin
                checks++;
                if (prev_strobe) begin
                    failures++;
                    $display("FAIL strobe_width: got 2 cycles expected 1");
                end
            end
        end
        prev_strobe = key_strobe;
    end

    initial begin
        ev_t e;
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_ext", key_extended, 0);
        chk("rst_code", key_code, 8'h00);
        chk("rst_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (10000) @(negedge clk_sys);
        chk("idle_code", key_code, 8'h00);
        chk("idle_strobe", key_strobe, 0);
        chk("idle_err", frame_err, 0);

        tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 0, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h75, 0, 0, 1, 8'h75, 1, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h75, 0, 0, 1, 8'h75, 0, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 1, 0, 2, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1D, 0, 0, 1, 8'h1D, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hAA, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hFA, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 1, 2, 8'h00, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(8'hE1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h14, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h77, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hE1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h14, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h77, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h29, 0, 0, 1, 8'h29, 1, 0));

        for (int i = 0; i < tbl.size(); i++) send_frame(tbl[i], 11);

        chk("hold_code", key_code, 8'h29);
        chk("hold_pressed", key_pressed, 1);

        // Truncated frame: error exactly TO cycles after the last sample.
        send_frame(mk(8'h45, 0, 0, 0, 8'h00, 0, 0), 5);
        e.kind = 2; e.code = 8'h00; e.pressed = 0; e.ext = 0;
        e.cyc = last_fall + TO + FL + 2;
        sb.push_back(e);
        repeat (TO + 100) @(negedge clk_sys);
        chk("timeout_drained", sb.size(), 0);
        send_frame(mk(8'h45, 0, 0, 1, 8'h45, 1, 0), 11);

        // Reset mid-frame after an E0 prefix: no event, prefix forgotten.
        send_frame(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0), 11);
        send_frame(mk(8'h1C, 0, 0, 0, 8'h00, 0, 0), 5);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("midrst_code", key_code, 8'h00);
        reset_n = 1'b1;
        repeat (TO + 200) @(negedge clk_sys);
        send_frame(mk(8'h1C, 0, 0, 1, 8'h1C, 1, 0), 11);

        repeat (200) @(negedge clk_sys);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
